// File: rtl/mem_access_ctrl.sv
// Arbitrating front end for the 256x16 unified memory: serialises fetch and data requests
// into a registered strobe bundle and returns responses. Optional bounds check: MEM_ACCESS_BOUNDS_EN.
module mem_access_ctrl #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_wdone,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              fault
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              op_dm;
  logic              op_we;
  logic              op_oob;

  logic              accept_window;
  logic              if_win;
  logic              dm_win;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oob;

  // Arbitration: data wins unless fetch has lost STARVE_LIMIT contested rounds in a row
  always_comb begin
    accept_window = (state == IDLE) || (state == RESP);
    if_win        = if_req && (!dm_req || (starve_cnt == CNT_W'(STARVE_LIMIT)));
    dm_win        = dm_req && !if_win;
    if_ready      = accept_window && if_win;
    dm_ready      = accept_window && dm_win;
    accept        = if_ready || dm_ready;
    sel_addr      = dm_win ? dm_addr : if_addr;
  end

`ifdef MEM_ACCESS_BOUNDS_EN
  assign sel_oob = (32'(sel_addr) >= 32'(DEPTH));
`else
  logic [31:0] unused_depth;
  assign sel_oob      = 1'b0;
  assign unused_depth = 32'(DEPTH);
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      op_dm      <= 1'b0;
      op_we      <= 1'b0;
      op_oob     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
      dm_wdone   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_wdone  <= 1'b0;

      case (state)
        // Read data is sampled at the end of the strobe cycle and routed to its source
        ISSUE: begin
          state <= RESP;
          if (op_dm) begin
            if (op_we) begin
              dm_wdone <= 1'b1;
            end else begin
              dm_rvalid <= 1'b1;
              dm_rdata  <= op_oob ? '0 : mem_rdata;
            end
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= op_oob ? '0 : mem_rdata;
          end
          if (op_oob) begin
            fault <= 1'b1;
          end
        end
        default: state <= accept ? ISSUE : IDLE;
      endcase

      if (accept) begin
        op_dm     <= dm_win;
        op_we     <= dm_win && dm_we;
        op_oob    <= sel_oob;
        mem_addr  <= sel_addr;
        mem_read  <= !(dm_win && dm_we) && !sel_oob;
        mem_write <= dm_win && dm_we && !sel_oob;
        if (dm_win) begin
          mem_wdata <= dm_wdata;
        end
        if (if_win) begin
          starve_cnt <= '0;
        end else if (if_req && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
